seq_reco_mc: RTL and testbench



---
 rtl/seq_reco_pkg.sv | 19 +
 rtl/seq_reco_mc_if.sv | 38 +++
 rtl/seq_reco_lane.sv | 113 +++++++++++
 rtl/seq_reco_mc.sv | 47 ++++
 tb/tb_seq_reco_mc.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_reco_pkg.sv
// Shared types and helpers for the seq_reco_mc recorrelator.
// Optional macro SEQ_RECO_STATS_EN enables the per-lane saturation counters.
package seq_reco_pkg;

    localparam int STAT_W = 16;
    // Wide enough for any practical DEPTH; occ exposes only the low SW bits.
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             sign;   // 1: pending ones sit on the a side
        logic             lmode;
    } lane_state_t;

    function automatic int reco_sw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/seq_reco_mc_if.sv
// Bus between a stream source/sink and seq_reco_mc.
// Optional macro SEQ_RECO_STATS_EN adds the sat_cnt bundle.
interface seq_reco_mc_if import seq_reco_pkg::*; #(
    parameter int NCH   = 4,
    parameter int DEPTH = 4
);
    localparam int SW = reco_sw(DEPTH);

    logic              en;
    logic              clr;
    logic              mode;
    logic [NCH-1:0]    x;
    logic [NCH-1:0]    y;
    logic [NCH-1:0]    x_reco_r;
    logic [NCH-1:0]    y_reco_r;
    logic [NCH*SW-1:0] occ;
    logic [NCH-1:0]    full;
`ifdef SEQ_RECO_STATS_EN
    logic [NCH*STAT_W-1:0] sat_cnt;
`endif

    modport master (
        output en, clr, mode, x, y,
        input  x_reco_r, y_reco_r, occ, full
`ifdef SEQ_RECO_STATS_EN
        , input sat_cnt
`endif
    );

    modport slave (
        input  en, clr, mode, x, y,
        output x_reco_r, y_reco_r, occ, full
`ifdef SEQ_RECO_STATS_EN
        , output sat_cnt
`endif
    );

endinterface

// File: rtl/seq_reco_lane.sv
// One recorrelator lane: pairing core, mode latch, output flops.
// Optional macro SEQ_RECO_STATS_EN adds a saturating saturation-event counter.
module seq_reco_lane import seq_reco_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int SW    = reco_sw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          mode_i,
    input  logic          x_i,
    input  logic          y_i,
    output logic          x_reco_o,
    output logic          y_reco_o,
    output logic [SW-1:0] occ_o,
    output logic          full_o
`ifdef SEQ_RECO_STATS_EN
    , output logic [STAT_W-1:0] sat_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    lane_state_t st_q, st_d;
    logic        xr_q, xr_d, yr_q, yr_d;
    logic        lm, a, b, oa, ob;

    always_comb begin
        st_d = st_q;
        xr_d = x_i;
        yr_d = y_i;
        lm   = st_q.lmode;
        a    = x_i;
        b    = y_i;
        oa   = x_i;
        ob   = y_i;
        if (clr_i) begin
            st_d.cnt   = '0;
            st_d.sign  = 1'b0;
            st_d.lmode = mode_i;
        end else if (en_i) begin
            // Mode may only change while nothing is pending in this lane.
            lm         = (st_q.cnt == '0) ? mode_i : st_q.lmode;
            st_d.lmode = lm;
            a          = x_i;
            b          = y_i ^ lm;
            oa         = a;
            ob         = b;
            if (a != b) begin
                if (st_q.cnt == '0) begin
                    oa        = 1'b0;
                    ob        = 1'b0;
                    st_d.cnt  = ONE_C;
                    st_d.sign = a;
                end else if (st_q.sign ? b : a) begin
                    oa       = 1'b1;
                    ob       = 1'b1;
                    st_d.cnt = st_q.cnt - ONE_C;
                end else if (st_q.cnt < DEPTH_C) begin
                    oa       = 1'b0;
                    ob       = 1'b0;
                    st_d.cnt = st_q.cnt + ONE_C;
                end
            end
            xr_d = oa;
            yr_d = ob ^ lm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
            xr_q <= 1'b0;
            yr_q <= 1'b0;
        end else begin
            st_q <= st_d;
            xr_q <= xr_d;
            yr_q <= yr_d;
        end
    end

    assign x_reco_o = xr_q;
    assign y_reco_o = yr_q;
    assign occ_o    = st_q.cnt[SW-1:0];
    assign full_o   = (st_q.cnt == DEPTH_C);

`ifdef SEQ_RECO_STATS_EN
    logic              sat_hit;
    logic [STAT_W-1:0] sat_q, sat_d;

    // Unpaired arrival on the already-full side: the bit passes through unpaired.
    assign sat_hit = en_i && !clr_i && (a != b) && (st_q.cnt == DEPTH_C)
                     && !(st_q.sign ? b : a);

    always_comb begin
        sat_d = sat_q;
        if (clr_i)
            sat_d = '0;
        else if (sat_hit && (sat_q != '1))
            sat_d = sat_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_q <= '0;
        else        sat_q <= sat_d;
    end

    assign sat_cnt_o = sat_q;
`endif

endmodule

// File: rtl/seq_reco_mc.sv
// Multi-lane sequential recorrelator: NCH independent lanes, slicing only.
// Optional macro SEQ_RECO_STATS_EN exposes per-lane saturation counters.
module seq_reco_mc import seq_reco_pkg::*; #(
    parameter int NCH   = 4,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    seq_reco_mc_if.slave bus
);

    localparam int SW = reco_sw(DEPTH);

    logic [NCH-1:0]    xr, yr, full;
    logic [NCH*SW-1:0] occ;
`ifdef SEQ_RECO_STATS_EN
    logic [NCH*STAT_W-1:0] sat;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        seq_reco_lane #(.DEPTH(DEPTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (bus.en),
            .clr_i    (bus.clr),
            .mode_i   (bus.mode),
            .x_i      (bus.x[i]),
            .y_i      (bus.y[i]),
            .x_reco_o (xr[i]),
            .y_reco_o (yr[i]),
            .occ_o    (occ[i*SW +: SW]),
            .full_o   (full[i])
`ifdef SEQ_RECO_STATS_EN
            , .sat_cnt_o (sat[i*STAT_W +: STAT_W])
`endif
        );
    end

    assign bus.x_reco_r = xr;
    assign bus.y_reco_r = yr;
    assign bus.occ      = occ;
    assign bus.full     = full;
`ifdef SEQ_RECO_STATS_EN
    assign bus.sat_cnt  = sat;
`endif

endmodule

// File: tb/tb_seq_reco_mc.sv
// Bench for seq_reco_mc: directed table, async reset, random vs. signed-pool model.
// Honours SEQ_RECO_STATS_EN for the sat_cnt checks.
module tb_seq_reco_mc;
    import seq_reco_pkg::*;

    localparam int NCH   = 4;
    localparam int DEPTH = 3;
    localparam int SW    = reco_sw(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_reco_mc_if #(.NCH(NCH), .DEPTH(DEPTH)) bus ();
    seq_reco_mc #(.NCH(NCH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pend > 0 means unmatched ones waiting from x, pend < 0 from y'.
    int             pend [NCH];
    int             sat  [NCH];
    logic [NCH-1:0] lmod, exr, eyr;

    typedef struct {
        logic en, clr, mode, x, y, xr, yr;
        int   occ;
        logic full;
        int   sat;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic en, clr, mode, x, y, xr, yr,
                       input int occ, input logic full, input int s);
        vec_t v;
        v.en = en; v.clr = clr; v.mode = mode; v.x = x; v.y = y;
        v.xr = xr; v.yr = yr; v.occ = occ; v.full = full; v.sat = s;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            pend[i] = 0;
            sat[i]  = 0;
        end
        lmod = '0; exr = '0; eyr = '0;
    endtask

    task automatic model_step(input logic en, clr, mode, input logic [NCH-1:0] x, y);
        logic a, b, oa, ob;
        for (int i = 0; i < NCH; i++) begin
            if (clr) begin
                pend[i] = 0; sat[i] = 0; lmod[i] = mode;
                exr[i] = x[i]; eyr[i] = y[i];
            end else if (!en) begin
                exr[i] = x[i]; eyr[i] = y[i];
            end else begin
                if (pend[i] == 0) lmod[i] = mode;
                a = x[i]; b = y[i] ^ lmod[i]; oa = a; ob = b;
                if (a && !b) begin
                    if (pend[i] < 0)          begin oa = 1; ob = 1; pend[i]++; end
                    else if (pend[i] < DEPTH) begin oa = 0; ob = 0; pend[i]++; end
                    else if (sat[i] < 65535) sat[i]++;
                end else if (b && !a) begin
                    if (pend[i] > 0)           begin oa = 1; ob = 1; pend[i]--; end
                    else if (pend[i] > -DEPTH) begin oa = 0; ob = 0; pend[i]--; end
                    else if (sat[i] < 65535) sat[i]++;
                end
                exr[i] = oa; eyr[i] = ob ^ lmod[i];
            end
        end
    endtask

    task automatic drive(input logic en, clr, mode, input logic [NCH-1:0] x, y);
        @(negedge clk);
        bus.en = en; bus.clr = clr; bus.mode = mode; bus.x = x; bus.y = y;
        model_step(en, clr, mode, x, y);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string nm, input logic [NCH-1:0] xr, yr, fl,
                           input logic [NCH*SW-1:0] oc);
        n_tests++;
        if (bus.x_reco_r !== xr || bus.y_reco_r !== yr || bus.occ !== oc || bus.full !== fl) begin
            n_fail++;
            $display("FAIL %s: x_reco_r=%b want %b y_reco_r=%b want %b occ=%h want %h full=%b want %b",
                     nm, bus.x_reco_r, xr, bus.y_reco_r, yr, bus.occ, oc, bus.full, fl);
        end
    endtask

    task automatic check_model(input string nm);
        logic [NCH*SW-1:0]     eo;
        logic [NCH-1:0]        ef;
        logic [NCH*STAT_W-1:0] es;
        int p;
        for (int i = 0; i < NCH; i++) begin
            p = (pend[i] < 0) ? -pend[i] : pend[i];
            eo[i*SW +: SW]         = SW'(p);
            ef[i]                  = (p == DEPTH);
            es[i*STAT_W +: STAT_W] = STAT_W'(sat[i]);
        end
        compare(nm, exr, eyr, ef, eo);
`ifdef SEQ_RECO_STATS_EN
        n_tests++;
        if (bus.sat_cnt !== es) begin
            n_fail++;
            $display("FAIL %s sat_cnt: got %h want %h", nm, bus.sat_cnt, es);
        end
`else
        if (es == '1) ;
`endif
    endtask

    task automatic check_row(input string nm, input vec_t v);
        logic [NCH*SW-1:0] eo;
        for (int i = 0; i < NCH; i++) eo[i*SW +: SW] = SW'(v.occ);
        compare(nm, {NCH{v.xr}}, {NCH{v.yr}}, {NCH{v.full}}, eo);
`ifdef SEQ_RECO_STATS_EN
        for (int i = 0; i < NCH; i++) begin
            n_tests++;
            if (bus.sat_cnt[i*STAT_W +: STAT_W] !== STAT_W'(v.sat)) begin
                n_fail++;
                $display("FAIL %s sat_cnt[%0d]: got %0d want %0d", nm, i,
                         bus.sat_cnt[i*STAT_W +: STAT_W], v.sat);
            end
        end
`endif
    endtask

    initial begin
        logic [NCH-1:0] rx, ry;
        logic           ren, rclr, rmode;
        int             inx [NCH], iny [NCH], outx [NCH], outy [NCH];

        bus.en = 0; bus.clr = 0; bus.mode = 0; bus.x = '0; bus.y = '0;
        model_reset();
        #3;
        compare("reset_state", '0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        //   en clr m  x  y  xr yr occ full sat
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);   // flush
        add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);   // pairing: hold x
        add(1, 0, 0, 0, 1, 1, 1, 0, 0, 0);   // pairing: emit 11
        add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 3, 1, 0);   // full
        add(1, 0, 0, 1, 0, 1, 0, 3, 1, 1);   // saturation pass-through
        add(1, 0, 0, 0, 1, 1, 1, 2, 0, 1);
        add(1, 0, 0, 0, 1, 1, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 1, 1, 0, 0, 1);
        add(1, 0, 0, 1, 1, 1, 1, 0, 0, 1);   // equal bits pass
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);   // flush, mode 1
        add(1, 0, 1, 1, 1, 0, 1, 1, 0, 0);   // anti
        add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);   // mode latch: take mode 0
        add(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);   // mode 1 ignored, pairs under 0
        add(1, 0, 1, 1, 1, 0, 1, 1, 0, 0);   // now mode 1
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // mode 0 ignored while pending
        add(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 2, 0, 0);   // stall
        add(0, 0, 0, 1, 0, 1, 0, 2, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 2, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 2, 0, 0);   // stall, raw, mode ignored
        add(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);   // clr beats en=0
        add(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);   // fresh start on y side

        foreach (tbl[k]) begin
            drive(tbl[k].en, tbl[k].clr, tbl[k].mode, {NCH{tbl[k].x}}, {NCH{tbl[k].y}});
            check_row($sformatf("row%0d", k), tbl[k]);
        end

        // Asynchronous reset in the middle of a cycle.
        drive(0, 0, 0, {NCH{1'b1}}, '0);
        check_model("pre_async_rst");
        #2 rst_n = 1'b0;
        #1 compare("async_rst", '0, '0, '0, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        rmode = 0;
        for (int k = 0; k < 300; k++) begin
            ren  = ($urandom_range(9) != 0);
            rclr = ($urandom_range(39) == 0);
            if ($urandom_range(7) == 0) rmode = ~rmode;
            rx = NCH'($urandom);
            ry = NCH'($urandom);
            drive(ren, rclr, rmode, rx, ry);
            check_model($sformatf("rnd%0d", k));
        end

        // Ones conservation, mode 0, per-lane stream densities.
        drive(1, 1, 0, '0, '0);
        for (int i = 0; i < NCH; i++) begin
            inx[i] = 0; iny[i] = 0; outx[i] = 0; outy[i] = 0;
        end
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < NCH; i++) begin
                rx[i] = ($urandom_range(7) < 2 + i);
                ry[i] = ($urandom_range(7) < 5 - i);
            end
            drive(1, 0, 0, rx, ry);
            check_model($sformatf("cons%0d", k));
            for (int i = 0; i < NCH; i++) begin
                inx[i]  += int'(rx[i]);
                iny[i]  += int'(ry[i]);
                outx[i] += int'(bus.x_reco_r[i]);
                outy[i] += int'(bus.y_reco_r[i]);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            n_tests++;
            if (outx[i] + (pend[i] > 0 ? pend[i] : 0) != inx[i] ||
                outy[i] + (pend[i] < 0 ? -pend[i] : 0) != iny[i]) begin
                n_fail++;
                $display("FAIL conserve lane%0d: outx=%0d outy=%0d pend=%0d want inx=%0d iny=%0d",
                         i, outx[i], outy[i], pend[i], inx[i], iny[i]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
